key_ctrl: RTL and testbench

KEY_CTRL -- requirements
Module: key_ctrl

---
 rtl/key_ctrl.sv | 149 ++++++++++++++
 tb/tb_key_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_ctrl.sv
// key_ctrl: four-button debouncer driving chase direction, speed and run/pause.
// Each key is synchronized, sampled on a slow prescaler tick and debounced by a
// small per-key FSM; accepted presses become one-clk pulses that update controls.
module key_ctrl #(
  parameter int unsigned DIV_EXP = 14,
  parameter int unsigned DB_CNT  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] key_in,
  output logic [3:0] key_pulse,
  output logic       dir,
  output logic [1:0] speed,
  output logic       run
);

  localparam int unsigned NKEY  = 4;
  localparam int unsigned CNT_W = 4;
  // The sample that causes entry into a CHK state is sample 1, so the counter
  // tracks the extra samples seen; the last qualifying sample arrives at DB_CNT-2.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CNT - 2);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DB_CNT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHK_P = 2'd1,
    HELD  = 2'd2,
    CHK_R = 2'd3
  } db_state_t;

  logic [NKEY-1:0]    r_sync1;
  logic [NKEY-1:0]    r_sync2;
  logic [DIV_EXP-1:0] r_div;
  logic               w_tick;
  db_state_t          r_state [NKEY];
  logic [CNT_W-1:0]   r_cnt   [NKEY];
  logic [NKEY-1:0]    r_pulse;
  logic               r_dir;
  logic [1:0]         r_speed;
  logic               r_run;

  // Two-flop synchronizer for the raw button levels
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= key_in;
      r_sync2 <= r_sync1;
    end
  end

  // Free-running prescaler; tick coincides with the all-ones to zero wrap
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_EXP'(1);
    end
  end

  assign w_tick = &r_div;

  // Per-key debounce FSM with sample counter; pulse only on CHK_P -> HELD
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NKEY; i++) begin
        r_state[i] <= IDLE;
        r_cnt[i]   <= '0;
      end
      r_pulse <= '0;
    end else begin
      r_pulse <= '0;
      if (w_tick) begin
        for (int i = 0; i < NKEY; i++) begin
          case (r_state[i])
            IDLE: begin
              if (r_sync2[i]) begin
                r_state[i] <= CHK_P;
                r_cnt[i]   <= '0;
              end
            end
            CHK_P: begin
              if (!r_sync2[i]) begin
                r_state[i] <= IDLE;
                r_cnt[i]   <= '0;
              end else if (r_cnt[i] >= CNT_LAST) begin
                r_state[i] <= HELD;
                r_cnt[i]   <= '0;
                r_pulse[i] <= 1'b1;
              end else if (r_cnt[i] != CNT_SAT) begin
                r_cnt[i] <= r_cnt[i] + CNT_W'(1);
              end
            end
            HELD: begin
              if (!r_sync2[i]) begin
                r_state[i] <= CHK_R;
                r_cnt[i]   <= '0;
              end
            end
            CHK_R: begin
              if (r_sync2[i]) begin
                r_state[i] <= HELD;
                r_cnt[i]   <= '0;
              end else if (r_cnt[i] >= CNT_LAST) begin
                r_state[i] <= IDLE;
                r_cnt[i]   <= '0;
              end else if (r_cnt[i] != CNT_SAT) begin
                r_cnt[i] <= r_cnt[i] + CNT_W'(1);
              end
            end
            default: begin
              r_state[i] <= IDLE;
              r_cnt[i]   <= '0;
            end
          endcase
        end
      end
    end
  end

  // Control registers updated from the accepted-press pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dir   <= 1'b0;
      r_speed <= 2'd0;
      r_run   <= 1'b1;
    end else begin
      if (r_pulse[0]) begin
        r_dir <= ~r_dir;
      end
      if (r_pulse[3]) begin
        r_run <= ~r_run;
      end
      // Up and down together cancel
      if (r_pulse[1] && !r_pulse[2] && (r_speed != 2'd3)) begin
        r_speed <= r_speed + 2'd1;
      end else if (r_pulse[2] && !r_pulse[1] && (r_speed != 2'd0)) begin
        r_speed <= r_speed - 2'd1;
      end
    end
  end

  assign key_pulse = r_pulse;
  assign dir       = r_dir;
  assign speed     = r_speed;
  assign run       = r_run;

endmodule

// File: tb/tb_key_ctrl.sv
// tb_key_ctrl: directed table, reset/glitch sequences and random key activity,
// all cross-checked against a run-length debounce model.
module tb_key_ctrl;

  localparam int unsigned DIV_EXP = 4;
  localparam int unsigned DB_CNT  = 4;
  localparam int          TICK    = 1 << DIV_EXP;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] key_in;
  logic [3:0] key_pulse;
  logic       dir;
  logic [1:0] speed;
  logic       run;

  int n_checks = 0;
  int n_fail   = 0;
  int pc [4];

  key_ctrl #(.DIV_EXP(DIV_EXP), .DB_CNT(DB_CNT)) dut (
    .clk       (clk),
    .reset     (reset),
    .key_in    (key_in),
    .key_pulse (key_pulse),
    .dir       (dir),
    .speed     (speed),
    .run       (run)
  );

  always #5 clk = ~clk;

  // Reference model state: accepted level and run length of differing samples
  logic [3:0] m_acc;
  logic [3:0] m_pulse;
  logic [3:0] h1;
  logic [3:0] h2;
  int         m_len [4];
  logic       m_dir;
  logic [1:0] m_speed;
  logic       m_run;
  int         m_cyc;

  initial begin : model_proc
    logic [3:0] samp;
    logic [3:0] np;
    int         s;
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        m_acc   = '0;
        m_pulse = '0;
        h1      = '0;
        h2      = '0;
        m_dir   = 1'b0;
        m_speed = 2'd0;
        m_run   = 1'b1;
        m_cyc   = 0;
        for (int i = 0; i < 4; i++) m_len[i] = 0;
      end else begin
        if (m_pulse[0]) m_dir = ~m_dir;
        if (m_pulse[3]) m_run = ~m_run;
        s = int'(m_speed) + (m_pulse[1] ? 1 : 0) - (m_pulse[2] ? 1 : 0);
        if (s < 0) s = 0;
        if (s > 3) s = 3;
        m_speed = 2'(s);
        samp = h2;
        h2   = h1;
        h1   = key_in;
        m_cyc++;
        np = '0;
        if ((m_cyc % TICK) == 0) begin
          for (int i = 0; i < 4; i++) begin
            if (samp[i] == m_acc[i]) begin
              m_len[i] = 0;
            end else begin
              m_len[i]++;
              if (m_len[i] == int'(DB_CNT)) begin
                m_acc[i] = samp[i];
                m_len[i] = 0;
                np[i]    = samp[i];
              end
            end
          end
        end
        m_pulse = np;
      end
    end
  end

  // Cycle-by-cycle comparison against the model on the falling edge
  initial begin : cmp_proc
    forever begin
      @(negedge clk);
      n_checks++;
      if (key_pulse !== m_pulse || dir !== m_dir || speed !== m_speed || run !== m_run) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t got pulse=%b dir=%b speed=%0d run=%b expected pulse=%b dir=%b speed=%0d run=%b",
                 $time, key_pulse, dir, speed, run, m_pulse, m_dir, m_speed, m_run);
      end
    end
  end

  typedef struct {
    logic [3:0] keys;
    int         ticks;
    logic [3:0] exp_p;
    logic       exp_dir;
    logic [1:0] exp_spd;
    logic       exp_run;
  } row_t;

  row_t rows [$];

  task automatic add_row(input logic [3:0] k, input int t, input logic [3:0] p,
                         input logic d, input logic [1:0] sp, input logic r);
    row_t x;
    x.keys = k; x.ticks = t; x.exp_p = p; x.exp_dir = d; x.exp_spd = sp; x.exp_run = r;
    rows.push_back(x);
  endtask

  task automatic run_cycles(input logic [3:0] k, input int n);
    key_in = k;
    repeat (n) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) if (key_pulse[i]) pc[i]++;
    end
  endtask

  task automatic clear_pc();
    for (int i = 0; i < 4; i++) pc[i] = 0;
  endtask

  task automatic check_pulses(input string name, input logic [3:0] exp_p);
    n_checks++;
    if (pc[0] != int'(exp_p[0]) || pc[1] != int'(exp_p[1]) ||
        pc[2] != int'(exp_p[2]) || pc[3] != int'(exp_p[3])) begin
      n_fail++;
      $display("FAIL %s pulse counts got k3..k0=%0d,%0d,%0d,%0d expected %b",
               name, pc[3], pc[2], pc[1], pc[0], exp_p);
    end
  endtask

  task automatic check_ctrl(input string name, input logic d, input logic [1:0] sp, input logic r);
    n_checks++;
    if (dir !== d || speed !== sp || run !== r) begin
      n_fail++;
      $display("FAIL %s got dir=%b speed=%0d run=%b expected dir=%b speed=%0d run=%b",
               name, dir, speed, run, d, sp, r);
    end
  endtask

  initial begin : main_proc
    logic [3:0] k;
    // keys, ticks, pulses expected, dir, speed, run after the row
    add_row(4'b0010, 10, 4'b0010, 1'b0, 2'd1, 1'b1);
    add_row(4'b0000,  5, 4'b0000, 1'b0, 2'd1, 1'b1);
    add_row(4'b0001,  1, 4'b0000, 1'b0, 2'd1, 1'b1);
    add_row(4'b0000,  1, 4'b0000, 1'b0, 2'd1, 1'b1);
    add_row(4'b0001,  1, 4'b0000, 1'b0, 2'd1, 1'b1);
    add_row(4'b0000,  1, 4'b0000, 1'b0, 2'd1, 1'b1);
    add_row(4'b0001,  6, 4'b0001, 1'b1, 2'd1, 1'b1);
    add_row(4'b0000,  5, 4'b0000, 1'b1, 2'd1, 1'b1);
    add_row(4'b0010,  5, 4'b0010, 1'b1, 2'd2, 1'b1);
    add_row(4'b0000,  5, 4'b0000, 1'b1, 2'd2, 1'b1);
    add_row(4'b0010,  5, 4'b0010, 1'b1, 2'd3, 1'b1);
    add_row(4'b0000,  5, 4'b0000, 1'b1, 2'd3, 1'b1);
    add_row(4'b0010,  5, 4'b0010, 1'b1, 2'd3, 1'b1);
    add_row(4'b0000,  5, 4'b0000, 1'b1, 2'd3, 1'b1);
    add_row(4'b0010,  5, 4'b0010, 1'b1, 2'd3, 1'b1);
    add_row(4'b0000,  5, 4'b0000, 1'b1, 2'd3, 1'b1);
    add_row(4'b0100,  5, 4'b0100, 1'b1, 2'd2, 1'b1);
    add_row(4'b0000,  5, 4'b0000, 1'b1, 2'd2, 1'b1);
    add_row(4'b0110,  5, 4'b0110, 1'b1, 2'd2, 1'b1);
    add_row(4'b0000,  5, 4'b0000, 1'b1, 2'd2, 1'b1);
    add_row(4'b0100,  5, 4'b0100, 1'b1, 2'd1, 1'b1);
    add_row(4'b0000,  5, 4'b0000, 1'b1, 2'd1, 1'b1);
    add_row(4'b0100,  5, 4'b0100, 1'b1, 2'd0, 1'b1);
    add_row(4'b0000,  5, 4'b0000, 1'b1, 2'd0, 1'b1);
    add_row(4'b0100,  5, 4'b0100, 1'b1, 2'd0, 1'b1);
    add_row(4'b0000,  5, 4'b0000, 1'b1, 2'd0, 1'b1);
    add_row(4'b0100,  5, 4'b0100, 1'b1, 2'd0, 1'b1);
    add_row(4'b0000,  2, 4'b0000, 1'b1, 2'd0, 1'b1);
    add_row(4'b0100,  3, 4'b0000, 1'b1, 2'd0, 1'b1);
    add_row(4'b0000,  5, 4'b0000, 1'b1, 2'd0, 1'b1);
    add_row(4'b1000,  5, 4'b1000, 1'b1, 2'd0, 1'b0);
    add_row(4'b0000,  5, 4'b0000, 1'b1, 2'd0, 1'b0);
    add_row(4'b1111,  5, 4'b1111, 1'b0, 2'd0, 1'b1);
    add_row(4'b0000,  5, 4'b0000, 1'b0, 2'd0, 1'b1);
    add_row(4'b1000,  5, 4'b1000, 1'b0, 2'd0, 1'b0);
    add_row(4'b0000,  5, 4'b0000, 1'b0, 2'd0, 1'b0);
    add_row(4'b0010,  5, 4'b0010, 1'b0, 2'd1, 1'b0);
    add_row(4'b0000,  5, 4'b0000, 1'b0, 2'd1, 1'b0);

    reset  = 1'b1;
    key_in = 4'b0000;
    clear_pc();
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    check_ctrl("reset_values", 1'b0, 2'd0, 1'b1);
    n_checks++;
    if (key_pulse !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_pulse got %b expected 0000", key_pulse);
    end
    reset = 1'b1;

    // Directed table, each row aligned to whole tick periods
    for (int r = 0; r < rows.size(); r++) begin
      clear_pc();
      run_cycles(rows[r].keys, rows[r].ticks * TICK);
      check_pulses($sformatf("row%0d", r), rows[r].exp_p);
      check_ctrl($sformatf("row%0d", r), rows[r].exp_dir, rows[r].exp_spd, rows[r].exp_run);
    end

    // Reset while key[3] is three samples into its press candidate
    clear_pc();
    run_cycles(4'b1000, 3 * TICK);
    check_pulses("pre_reset_chk_p", 4'b0000);
    check_ctrl("pre_reset_chk_p", 1'b0, 2'd1, 1'b0);
    #3 reset = 1'b0;
    #1;
    check_ctrl("mid_reset", 1'b0, 2'd0, 1'b1);
    n_checks++;
    if (key_pulse !== 4'b0000) begin
      n_fail++;
      $display("FAIL mid_reset_pulse got %b expected 0000", key_pulse);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    clear_pc();
    run_cycles(4'b1000, 5 * TICK);
    check_pulses("post_reset_press", 4'b1000);
    check_ctrl("post_reset_press", 1'b0, 2'd0, 1'b0);
    clear_pc();
    run_cycles(4'b0000, 5 * TICK);
    check_pulses("post_reset_release", 4'b0000);

    // Short glitches falling between ticks
    clear_pc();
    for (int g = 0; g < 4; g++) begin
      run_cycles(4'b0000, 4);
      run_cycles(4'b1111, 3);
      run_cycles(4'b0000, TICK - 7);
    end
    check_pulses("glitch", 4'b0000);
    check_ctrl("glitch", 1'b0, 2'd0, 1'b0);

    // Random slowly-changing key levels, checked by the model every cycle
    k = 4'b0000;
    for (int c = 0; c < 6000; c++) begin
      if ($urandom_range(0, 39) == 0) k[$urandom_range(0, 3)] = ~k[$urandom_range(0, 3)];
      if ($urandom_range(0, 39) == 0) k = 4'($urandom);
      run_cycles(k, 1);
    end
    run_cycles(4'b0000, 8 * TICK);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
